ldl_rr_arbiter_v1: RTL
======================

# ldl_rr_arbiter_v1

Round-robin arbiter that shares one resource among 2^BIN_WIDTH requesters. It holds each grant until the resource signals completion, the requester withdraws, or a watchdog expires. Grant identity is presented both one-hot and binary, so the arbiter can drive a resource mux select directly. It sits between requesting engines and any single-ported shared datapath in the library.

## Interface
- BIN_WIDTH, 3, width of binary grant index; N = 1<<BIN_WIDTH requesters.
- TIMEOUT, 16, maximum grant length in cycles; 0 disables the watchdog.
- CNT_WIDTH, 16, watchdog counter width; TIMEOUT must be < 2^CNT_WIDTH.

- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  N  per-requester request, level; held until granted and served.
- done  in  1  resource completes the current grant; sampled only while gnt_valid=1.
- err_clr  in  1  clears timeout_err.
- gnt  out  N  one-hot grant, registered; all-zero when no grant.
- gnt_id  out  BIN_WIDTH  binary index of the granted requester, registered; holds its last value when idle.
- gnt_valid  out  1  grant active (OR of gnt).
- timeout_err  out  1  sticky flag, set by a watchdog release.

## Operation
- State machine with 2 states: IDLE, BUSY. Reset state is IDLE.
- Round-robin pointer ptr (BIN_WIDTH bits), reset 0. Priority order is ptr, ptr+1, …, N-1, 0, …, ptr-1. The winner is the first set bit of req in that order. Implementation: masked priority encode of req & (all-ones << ptr), falling back to an unmasked encode when the masked result is empty.
- IDLE:
  - If req != 0: register gnt = onehot(winner), gnt_id = winner, clear the counter, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, release conditions, highest priority first:
  - (a) done=1: normal release.
  - (b) req[gnt_id]=0: requester withdrew.
  - (c) TIMEOUT!=0 and cnt==TIMEOUT-1: watchdog release; set timeout_err.
- On any release:
  - gnt <= 0, go to IDLE.
  - ptr <= gnt_id+1 mod N; wraps from N-1 to 0.
  - gnt_id keeps its value.
- Otherwise in BUSY: cnt <= cnt+1, and gnt/gnt_id hold. Changes on req for other requesters are ignored during BUSY.
- Simultaneous done and watchdog expiry: done wins; timeout_err is not set.
- timeout_err: a set and err_clr in the same cycle leaves it set. err_clr while already clear has no effect.
- The arbiter never issues a grant to a requester whose req is low at the arbitration edge.
- Asserting rst_n low in any state immediately clears gnt, gnt_valid, gnt_id, ptr, cnt and timeout_err, and forces IDLE. An in-flight grant is abandoned without a done.

## Timing
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout_err=0; internal ptr=0, cnt=0, state=IDLE.
- Arbitration latency: req first high at edge k (IDLE) gives gnt/gnt_valid high from edge k+1.
- Release: done high at edge m gives gnt=0 from edge m+1. Minimum grant length is 1 cycle (done in the first granted cycle).
- One mandatory IDLE bubble between grants. With continuous requests, consecutive grants start 2 cycles apart at minimum.
- Watchdog: with no done, gnt_valid stays high for exactly TIMEOUT cycles; timeout_err rises on the same edge gnt falls.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
Scenarios use BIN_WIDTH=2 (N=4) and TIMEOUT=8.
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, gnt_id=0, gnt_valid=0, timeout_err=0. Release reset → first grant gnt=4'b0001 one cycle later.
- Fairness: req=4'b1111 held, done pulsed in every granted cycle → gnt_id sequence 0,1,2,3,0,1; each grant is 1 cycle long, separated by 1 idle cycle.
- Wrap: serve id 1 (ptr=2), then req=4'b0011 → gnt_id=0 (wrap past 2 and 3); afterwards ptr=1, and req=4'b0011 → gnt_id=1.
- Watchdog: req=4'b0100, done=0 → gnt=4'b0100 for exactly 8 cycles, then gnt=0 and timeout_err=1. err_clr pulse → timeout_err=0. Repeat with done asserted in the 8th cycle → timeout_err stays 0.
- Withdrawal: grant id 2 with req=4'b1100, then drop req[2] → gnt=0 next edge; next grant is id 3.
- Reset mid-grant: grant active on id 3, pulse rst_n low for 1 cycle asynchronously → outputs clear immediately without waiting for a clock edge. After reset, req=4'b1010 → gnt_id=1 (ptr back at 0).

Source files
------------

// File: rtl/ldl_rr_arbiter_v1.sv
// Round-robin arbiter for 2^BIN_WIDTH requesters. A grant is held until done,
// the requester withdraws, or the watchdog expires. Grant is both one-hot and binary.
module ldl_rr_arbiter_v1 #(
  parameter int BIN_WIDTH = 3,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(1<<BIN_WIDTH)-1:0]     req,
  input  logic                          done,
  input  logic                          err_clr,
  output logic [(1<<BIN_WIDTH)-1:0]     gnt,
  output logic [BIN_WIDTH-1:0]          gnt_id,
  output logic                          gnt_valid,
  output logic                          timeout_err
);

  localparam int unsigned N = 1 << BIN_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_n;
  logic [N-1:0]         gnt_n;
  logic [BIN_WIDTH-1:0] id_n;
  logic [BIN_WIDTH-1:0] ptr, ptr_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic                 terr_n;

  logic [N-1:0]         mask;
  logic [N-1:0]         masked;
  logic [BIN_WIDTH-1:0] winner;
  logic                 wd_hit;

  function automatic logic [BIN_WIDTH-1:0] first_set(input logic [N-1:0] v);
    logic found;
    first_set = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i] && !found) begin
        first_set = BIN_WIDTH'(i);
        found     = 1'b1;
      end
    end
  endfunction

  // Requests at or above ptr take precedence; wrap to the unmasked set when none.
  always_comb begin
    mask   = '1;
    mask   = mask << ptr;
    masked = req & mask;
    winner = (masked != '0) ? first_set(masked) : first_set(req);
  end

  assign wd_hit = (TIMEOUT != 0) && (cnt == CNT_WIDTH'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    cnt_n   = cnt;
    terr_n  = timeout_err;
    if (err_clr) terr_n = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          gnt_n   = N'(1) << winner;
          id_n    = winner;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (done || !req[gnt_id] || wd_hit) begin
          gnt_n   = '0;
          ptr_n   = gnt_id + BIN_WIDTH'(1);
          state_n = IDLE;
          // Watchdog only flags when neither done nor withdrawal released first.
          if (!done && req[gnt_id]) terr_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      gnt_id      <= id_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule
